ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit for the L1 core. It is the producer end of the `o_sys_valid`/`i_sys_ready` handshake that the decode stage consumes.
- Owns the fetch PC and issues one-outstanding fetch requests to instruction RAM.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode.
- Handles redirects from the execute stage (jump/branch taken) by flushing the FIFO and dropping stale responses.

Parameters:
- P_RST_PC, 32'h8000_0000, PC fetched first after reset.
- P_BUF_DEPTH, 2, instruction FIFO entries; legal values 2..4.

Ports:
- i_sys_clk  in  1  clock; all state on rising edge.
- i_sys_rst  in  1  reset, asynchronous, active-high.
- o_ifu_ram_req_valid  out  1  fetch request valid.
- i_ifu_ram_req_ready  in  1  RAM accepts request this cycle.
- o_ifu_ram_req_addr  out  `ADDR_WIDTH  fetch address; always 4-byte aligned.
- i_ifu_ram_resp_valid  in  1  instruction returned; in order, at least 1 cycle after acceptance.
- i_ifu_ram_resp_inst  in  `INST_WIDTH  returned instruction.
- i_exu_jmp_en  in  1  redirect request.
- i_exu_jmp_pc  in  `ADDR_WIDTH  redirect target.
- o_sys_valid  out  1  instruction available to decode.
- i_sys_ready  in  1  decode accepts.
- o_ifu_inst  out  `INST_WIDTH  FIFO head instruction.
- o_ifu_pc  out  `ADDR_WIDTH  FIFO head PC.

Behaviour:
- Reset (async, while i_sys_rst=1):
  - state=S_IDLE, fetch PC=P_RST_PC, FIFO count=0.
  - o_ifu_ram_req_valid=0, o_ifu_ram_req_addr=P_RST_PC, o_sys_valid=0, o_ifu_inst=0, o_ifu_pc=0.
- Reset asserted mid-operation discards any outstanding request; a response arriving after reset release is ignored.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_DROP. Transitions:
  - S_IDLE: -> S_REQ unconditionally on the first edge after reset release.
  - S_REQ: o_ifu_ram_req_valid = (count < P_BUF_DEPTH); addr = fetch PC. On accept (valid&ready): fetch PC += 4 (wraps mod 2^ADDR_WIDTH), store req PC, -> S_WAIT.
  - S_WAIT: on i_ifu_ram_resp_valid, push {req PC, inst} into the FIFO, -> S_REQ.
  - S_DROP: on i_ifu_ram_resp_valid, discard the response, -> S_REQ.
- At most one request outstanding, so a response always finds FIFO space. Peak throughput is 1 instruction per 2 cycles.
- Latency: reset release edge E, first request visible at E+1, response at cycle N, o_sys_valid=1 from N+1 (FIFO registered, no bypass).
- Decode handshake:
  - o_sys_valid = (count!=0) & ~i_exu_jmp_en.
  - Pop on o_sys_valid & i_sys_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - When empty, o_ifu_inst=0 and o_ifu_pc=0.
- Redirect (i_exu_jmp_en=1 at an edge) has priority over every other event:
  - FIFO flushed (count=0).
  - Fetch PC = {i_exu_jmp_pc[ADDR-1:2],2'b00}.
  - Next state by current state:
    - S_REQ with accept that cycle: -> S_DROP.
    - S_REQ without accept: -> S_REQ. The request is withdrawn and the new address appears next cycle; this is the only legal withdrawal.
    - S_WAIT with response that cycle: response dropped, -> S_REQ.
    - S_WAIT without response: -> S_DROP.
    - S_DROP: stays S_DROP (PC updated), unless a response arrives that cycle, in which case the response is dropped and the state goes -> S_REQ.
    - S_IDLE: -> S_REQ with the new PC.
- FIFO full: S_REQ holds req_valid=0 until a pop occurs.

Optional Feature:
- Macro IFU_PERF_EN. When defined, two extra outputs:
  - o_ifu_perf_fetch_cnt [31:0]: increments on each decode handshake.
  - o_ifu_perf_drop_cnt [31:0]: increments on each discarded response, and on each FIFO entry flushed by a redirect (adds count).
  - Both reset to 0 and wrap.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- cfg.sv gains `IFU_STA_IDLE/REQ/WAIT/DROP` (2-bit encodings) and `IFU_RST_PC`; P_RST_PC defaults to it.
- One sub-module, ifu_buf:
  - Synchronous FIFO of {pc, inst}, depth P_BUF_DEPTH.
  - Ports push/pop/flush, count, head data.
  - Same clock and async active-high reset.

Test Plan:
- Reset release, RAM ready=1, response 1 cycle later with 32'h00000013 -> req addr 8000_0000 at E+1; o_sys_valid=1, o_ifu_pc=8000_0000 at E+3; next req addr 8000_0004.
- i_sys_ready=0 for 10 cycles -> exactly 2 entries fetched (8000_0000, 8000_0004), req_valid stays 0 after that. Raising ready pops them in order.
- Redirect to 8000_0103 in S_WAIT, response arrives 2 cycles later -> response dropped, FIFO empty, next req addr 8000_0100, no stale instruction delivered.
- Redirect in the same cycle as a response and a decode handshake -> FIFO count=0 next cycle, o_sys_valid=0 in the redirect cycle, next req addr is the target.
- Fetch PC FFFF_FFFC accepted -> next req addr 0000_0000.
- Assert i_sys_rst while in S_WAIT, then send the late response after release -> response ignored, first req addr 8000_0000. With IFU_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, reset PC, FSM state encodings and FIFO entry type for the fetch unit.
package ifu_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] IFU_RST_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } ifu_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } ifu_entry_t;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(3);
    endfunction
endpackage

// File: rtl/ifu_buf.sv
// ifu_buf: small synchronous FIFO of {pc, inst} with flush; head reads zero when empty.
module ifu_buf
    import ifu_pkg::*;
#(
    parameter int P_DEPTH = 2,
    parameter int P_CW    = $clog2(P_DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  ifu_entry_t      i_data,
    output logic [P_CW-1:0] o_count,
    output ifu_entry_t      o_head
);
    localparam int PW = $clog2(P_DEPTH);

    ifu_entry_t      mem_q [P_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [P_CW-1:0] cnt_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (i_flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (i_push) wr_q <= nxt(wr_q);
            if (i_pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + P_CW'(i_push) - P_CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem_q[wr_q] <= i_data;
    end

    assign o_count = cnt_q;
    assign o_head  = (cnt_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit with one outstanding RAM request, redirect handling and a decode FIFO.
// Defining IFU_PERF_EN adds fetch/drop performance counter outputs.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] P_RST_PC    = IFU_RST_PC,
    parameter int                    P_BUF_DEPTH = 2
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    output logic                  o_ifu_ram_req_valid,
    input  logic                  i_ifu_ram_req_ready,
    output logic [ADDR_WIDTH-1:0] o_ifu_ram_req_addr,
    input  logic                  i_ifu_ram_resp_valid,
    input  logic [INST_WIDTH-1:0] i_ifu_ram_resp_inst,
    input  logic                  i_exu_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
    output logic                  o_sys_valid,
    input  logic                  i_sys_ready,
    output logic [INST_WIDTH-1:0] o_ifu_inst,
    output logic [ADDR_WIDTH-1:0] o_ifu_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]           o_ifu_perf_fetch_cnt,
    output logic [31:0]           o_ifu_perf_drop_cnt
`endif
);
    localparam int CW = $clog2(P_BUF_DEPTH + 1);

    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic                  accept, push, pop, drop_resp;
    logic [CW-1:0]         count;
    ifu_entry_t            head;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q  <= S_IDLE;
            pc_q     <= P_RST_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // A redirect with a request in flight parks in S_DROP until that stale response returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = accept ? (i_exu_jmp_en ? S_DROP : S_WAIT) : S_REQ;
            S_WAIT:  state_d = i_ifu_ram_resp_valid ? S_REQ : (i_exu_jmp_en ? S_DROP : S_WAIT);
            default: state_d = i_ifu_ram_resp_valid ? S_REQ : S_DROP;
        endcase
        pc_d     = i_exu_jmp_en ? word_align(i_exu_jmp_pc) : accept ? pc_q + ADDR_WIDTH'(4) : pc_q;
        req_pc_d = accept ? pc_q : req_pc_q;
    end

    always_comb begin
        o_ifu_ram_req_valid = (state_q == S_REQ) && (count < CW'(P_BUF_DEPTH));
        o_ifu_ram_req_addr  = pc_q;
        accept    = o_ifu_ram_req_valid && i_ifu_ram_req_ready;
        push      = (state_q == S_WAIT) && i_ifu_ram_resp_valid && !i_exu_jmp_en;
        drop_resp = i_ifu_ram_resp_valid && ((state_q == S_DROP) || ((state_q == S_WAIT) && i_exu_jmp_en));
        o_sys_valid = (count != '0) && !i_exu_jmp_en;
        pop        = o_sys_valid && i_sys_ready;
        o_ifu_inst = head.inst;
        o_ifu_pc   = head.pc;
    end

    ifu_buf #(.P_DEPTH(P_BUF_DEPTH)) u_buf (
        .i_clk   (i_sys_clk),
        .i_rst   (i_sys_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_exu_jmp_en),
        .i_data  ('{pc: req_pc_q, inst: i_ifu_ram_resp_inst}),
        .o_count (count),
        .o_head  (head)
    );

`ifdef IFU_PERF_EN
    logic [31:0] fetch_cnt_q, drop_cnt_q;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(pop);
            drop_cnt_q  <= drop_cnt_q + 32'(drop_resp) + (i_exu_jmp_en ? 32'(count) : 32'd0);
        end
    end

    assign o_ifu_perf_fetch_cnt = fetch_cnt_q;
    assign o_ifu_perf_drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: cycle-by-cycle vector table for the fetch unit plus a mid-operation reset sequence.
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_v, ram_rdy = 0, resp_v = 0, jmp = 0, sv, sys_rdy = 0;
    logic [31:0] req_addr, resp_inst = 0, jmp_pc = 0, inst, pc;
`ifdef IFU_PERF_EN
    logic [31:0] fcnt, dcnt;
`endif
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    ifu dut (
        .i_sys_clk            (clk),
        .i_sys_rst            (rst),
        .o_ifu_ram_req_valid  (req_v),
        .i_ifu_ram_req_ready  (ram_rdy),
        .o_ifu_ram_req_addr   (req_addr),
        .i_ifu_ram_resp_valid (resp_v),
        .i_ifu_ram_resp_inst  (resp_inst),
        .i_exu_jmp_en         (jmp),
        .i_exu_jmp_pc         (jmp_pc),
        .o_sys_valid          (sv),
        .i_sys_ready          (sys_rdy),
        .o_ifu_inst           (inst),
        .o_ifu_pc             (pc)
`ifdef IFU_PERF_EN
        ,
        .o_ifu_perf_fetch_cnt (fcnt),
        .o_ifu_perf_drop_cnt  (dcnt)
`endif
    );

    typedef struct {
        logic        rr, rv;
        logic [31:0] ri;
        logic        j;
        logic [31:0] jp;
        logic        sr, e_rv;
        logic [31:0] e_addr;
        logic        e_sv;
        logic [31:0] e_inst, e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rr, rv, input logic [31:0] ri, input logic j,
                       input logic [31:0] jp, input logic sr, e_rv, input logic [31:0] e_addr,
                       input logic e_sv, input logic [31:0] e_inst, e_pc);
        vec_t v;
        v = '{rr, rv, ri, j, jp, sr, e_rv, e_addr, e_sv, e_inst, e_pc};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_rv, input logic [31:0] e_addr,
                            input logic e_sv, input logic [31:0] e_inst, e_pc);
        chk({tag, " req_valid"}, 32'(req_v), 32'(e_rv));
        chk({tag, " req_addr"}, req_addr, e_addr);
        chk({tag, " sys_valid"}, 32'(sv), 32'(e_sv));
        chk({tag, " inst"}, inst, e_inst);
        chk({tag, " pc"}, pc, e_pc);
    endtask

    initial begin
        // cycles c0..c25 counted from reset release; c0 is the S_IDLE cycle
        add(0, 0, 0, 0, 0, 0,              0, 32'h8000_0000, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,              1, 32'h8000_0000, 0, 0, 0);
        add(0, 1, 32'h13, 0, 0, 0,         0, 32'h8000_0004, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,              1, 32'h8000_0004, 1, 32'h13, 32'h8000_0000);
        add(0, 1, 32'h0010_0093, 0, 0, 0,  0, 32'h8000_0008, 1, 32'h13, 32'h8000_0000);
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 0, 0, 0,          0, 32'h8000_0008, 1, 32'h13, 32'h8000_0000);
        add(0, 0, 0, 0, 0, 1,              0, 32'h8000_0008, 1, 32'h13, 32'h8000_0000);
        add(0, 0, 0, 0, 0, 1,              1, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0004);
        add(1, 0, 0, 0, 0, 1,              1, 32'h8000_0008, 0, 0, 0);
        add(0, 0, 0, 1, 32'h8000_0103, 0,  0, 32'h8000_000C, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,              0, 32'h8000_0100, 0, 0, 0);
        add(0, 1, 32'hDEAD_BEEF, 0, 0, 1,  0, 32'h8000_0100, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,              1, 32'h8000_0100, 0, 0, 0);
        add(0, 1, 32'h1111_1111, 0, 0, 0,  0, 32'h8000_0104, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,              1, 32'h8000_0104, 1, 32'h1111_1111, 32'h8000_0100);
        add(0, 1, 32'h2222_2222, 1, 32'h2000_0040, 1,
                                           0, 32'h8000_0108, 0, 32'h1111_1111, 32'h8000_0100);
        add(0, 0, 0, 0, 0, 0,              1, 32'h2000_0040, 0, 0, 0);
        add(0, 0, 0, 1, 32'hFFFF_FFFC, 0,  1, 32'h2000_0040, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,              1, 32'hFFFF_FFFC, 0, 0, 0);
        add(0, 1, 32'h0000_0073, 0, 0, 0,  0, 32'h0000_0000, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1,              1, 32'h0000_0000, 1, 32'h0000_0073, 32'hFFFF_FFFC);
        add(1, 0, 0, 1, 32'h8000_0200, 0,  1, 32'h0000_0000, 0, 0, 0);
        add(0, 1, 32'h3333_3333, 1, 32'h8000_0300, 0,
                                           0, 32'h8000_0200, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,              1, 32'h8000_0300, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        #1 chk_outs("reset", 0, 32'h8000_0000, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            ram_rdy = vecs[i].rr; resp_v = vecs[i].rv; resp_inst = vecs[i].ri;
            jmp = vecs[i].j; jmp_pc = vecs[i].jp; sys_rdy = vecs[i].sr;
            #1 chk_outs($sformatf("c%0d", i), vecs[i].e_rv, vecs[i].e_addr,
                        vecs[i].e_sv, vecs[i].e_inst, vecs[i].e_pc);
            @(negedge clk);
        end

        // accept a request so the unit sits in S_WAIT, then reset it
        ram_rdy = 1; resp_v = 0; jmp = 0; sys_rdy = 0;
        #1 chk_outs("pre_rst", 1, 32'h8000_0300, 0, 0, 0);
`ifdef IFU_PERF_EN
        chk("perf_fetch", fcnt, 32'd3);
        chk("perf_drop", dcnt, 32'd4);
`endif
        @(negedge clk);
        rst = 1'b1; ram_rdy = 0;
        #1 chk_outs("mid_rst", 0, 32'h8000_0000, 0, 0, 0);
`ifdef IFU_PERF_EN
        chk("perf_fetch_rst", fcnt, 32'd0);
        chk("perf_drop_rst", dcnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; resp_v = 1; resp_inst = 32'h4444_4444;
        #1 chk_outs("late_idle", 0, 32'h8000_0000, 0, 0, 0);
        @(negedge clk);
        #1 chk_outs("late_req", 1, 32'h8000_0000, 0, 0, 0);
        @(negedge clk);
        resp_v = 0;
        #1 chk_outs("after_late", 1, 32'h8000_0000, 0, 0, 0);
`ifdef IFU_PERF_EN
        chk("perf_fetch_end", fcnt, 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
